mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the 64x16 single-port memory: instruction fetch vs data bursts.
// Optional ARB_ROUND_ROBIN_EN: ties alternate; otherwise the data port always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IF_RD = 3'd1,
    ST_D_RD  = 3'd2,
    ST_D_WR  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [ADDR_W-1:0]  beat_addr_r;
  logic [LEN_W-1:0]   remain_r;
  logic               wr_gap_r;
  logic               grant_data_s;
  logic               grant_fetch_s;

  // Grant decision; a done pulse still visible blocks a new grant for one cycle.
  always_comb begin
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    if (if_done || d_done) begin
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data_s  = d_req && (!if_req || !owner);
`else
      grant_data_s  = d_req;
`endif
      grant_fetch_s = if_req && !grant_data_s;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_r     <= ST_IDLE;
      beat_addr_r <= '0;
      remain_r    <= '0;
      wr_gap_r    <= 1'b0;
      mem_write   <= 1'b1;
      mem_read    <= 1'b1;
      mem_addr    <= '0;
      mem_in      <= '0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      d_rvalid    <= 1'b0;
      d_wnext     <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      owner       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      d_rvalid <= 1'b0;
      d_wnext  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_data_s) begin
            owner       <= 1'b1;
            busy        <= 1'b1;
            beat_addr_r <= d_addr;
            remain_r    <= d_len;
            mem_addr    <= d_addr;
            wr_gap_r    <= 1'b0;
            if (d_we) begin
              state_r   <= ST_D_WR;
              mem_write <= 1'b0;
              mem_in    <= d_wdata;
            end else begin
              state_r   <= ST_D_RD;
              mem_read  <= 1'b0;
            end
          end else if (grant_fetch_s) begin
            owner       <= 1'b0;
            busy        <= 1'b1;
            beat_addr_r <= if_addr;
            mem_addr    <= if_addr;
            mem_read    <= 1'b0;
            state_r     <= ST_IF_RD;
          end else begin
            busy        <= 1'b0;
          end
        end
        ST_IF_RD: begin
          if_rdata <= mem_out;
          if_done  <= 1'b1;
          mem_read <= 1'b1;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        ST_D_RD: begin
          // Every edge here closes a strobed beat, so the read data is live.
          d_rdata  <= mem_out;
          d_rvalid <= 1'b1;
          if (remain_r == '0) begin
            mem_read <= 1'b1;
            d_done   <= 1'b1;
            state_r  <= ST_FLUSH;
          end else begin
            remain_r    <= remain_r - LEN_ONE;
            beat_addr_r <= beat_addr_r + ADDR_ONE;
            mem_addr    <= beat_addr_r + ADDR_ONE;
          end
        end
        ST_D_WR: begin
          // The requester only updates d_wdata after seeing d_wnext,
          // so each written beat is followed by a strobe-high turnaround cycle.
          if (!wr_gap_r) begin
            mem_write <= 1'b1;
            d_wnext   <= 1'b1;
            if (remain_r == '0) begin
              d_done  <= 1'b1;
              state_r <= ST_FLUSH;
            end else begin
              wr_gap_r    <= 1'b1;
              remain_r    <= remain_r - LEN_ONE;
              beat_addr_r <= beat_addr_r + ADDR_ONE;
            end
          end else begin
            wr_gap_r  <= 1'b0;
            mem_write <= 1'b0;
            mem_in    <= d_wdata;
            mem_addr  <= beat_addr_r;
          end
        end
        ST_FLUSH: begin
          mem_read  <= 1'b1;
          mem_write <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          mem_read  <= 1'b1;
          mem_write <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
